// File: rtl/pll_usb_supervisor_pkg.sv
// ---------------------------------------------------------------------------
// pll_usb_supervisor_pkg
// Shared types and constants for the USB PLL supervisor.
//   state_t       : supervisor FSM states
//   CNT_W         : width of the edge / lock-loss counters (saturating)
//   DEF_*         : default values for the supervisor parameters
//   sat_inc()     : saturating increment used by every CNT_W counter
// ---------------------------------------------------------------------------
package pll_usb_supervisor_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABILIZE = 3'd1,
      MEASURE   = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   localparam int CNT_W = 8;

   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_WINDOW_CYCLES      = 1000;
   localparam int DEF_FREQ_MIN           = 118;
   localparam int DEF_FREQ_MAX           = 122;
   localparam int DEF_FAULT_HOLDOFF      = 256;
   localparam int DEF_SYNC_STAGES        = 2;

   // Adds inc to v but sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             inc);
      return (inc && (v != '1)) ? v + 1'b1 : v;
   endfunction

endpackage

// File: rtl/pll_usb_supervisor_sync.sv
// ---------------------------------------------------------------------------
// sync_bit
// Multi-flop synchronizer for a single asynchronous bit, synchronous reset.
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronized output, STAGES cycles after d changes
// ---------------------------------------------------------------------------
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_reg;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_reg[gi] <= 1'b0;
            end else if (gi == 0) begin
               sync_reg[gi] <= d;
            end else begin
               sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
            end
         end
      end
   endgenerate

   assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_usb_supervisor.sv
// ---------------------------------------------------------------------------
// pll_usb_supervisor
// Qualifies USB PLL lock, measures the 12 MHz USB clock (sampled as data on
// the 100 MHz clock) and sequences the USB-domain reset.
//   clk             : 100 MHz PLL output, all logic on the rising edge
//   rst             : synchronous active-high reset
//   pll_locked      : PLL lock, asynchronous
//   usb_clk_sample  : 12 MHz clock routed as data, asynchronous
//   usb_reset       : USB-domain reset, low only in RUN
//   ready           : high only in RUN
//   freq_count      : rising-edge count of the last completed window
//   freq_valid      : one-cycle pulse when freq_count updates
//   lock_lost_count : saturating count of sync'd lock falling edges
//   fault           : high in FAULT
// ---------------------------------------------------------------------------
module pll_usb_supervisor
   import pll_usb_supervisor_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int WINDOW_CYCLES      = DEF_WINDOW_CYCLES,
   parameter int FREQ_MIN           = DEF_FREQ_MIN,
   parameter int FREQ_MAX           = DEF_FREQ_MAX,
   parameter int FAULT_HOLDOFF      = DEF_FAULT_HOLDOFF,
   parameter int SYNC_STAGES        = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             usb_clk_sample,
   output logic             usb_reset,
   output logic             ready,
   output logic [CNT_W-1:0] freq_count,
   output logic             freq_valid,
   output logic [CNT_W-1:0] lock_lost_count,
   output logic             fault
);

   localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int WIN_W  = (WINDOW_CYCLES > 1)      ? $clog2(WINDOW_CYCLES)      : 1;
   localparam int HOLD_W = (FAULT_HOLDOFF > 1)      ? $clog2(FAULT_HOLDOFF)      : 1;

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAULT_HOLDOFF - 1);
   localparam logic [CNT_W-1:0]  F_MIN     = CNT_W'(FREQ_MIN);
   localparam logic [CNT_W-1:0]  F_MAX     = CNT_W'(FREQ_MAX);

   // ---------------------------------------------------------------------
   // Input synchronizers and edge detectors
   // ---------------------------------------------------------------------
   logic lock_s;
   logic usb_s;
   logic usb_d_reg;
   logic lock_d_reg;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_usb (
      .clk (clk),
      .rst (rst),
      .d   (usb_clk_sample),
      .q   (usb_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         usb_d_reg  <= 1'b0;
         lock_d_reg <= 1'b0;
      end else begin
         usb_d_reg  <= usb_s;
         lock_d_reg <= lock_s;
      end
   end

   logic usb_edge;
   logic lock_fall;

   assign usb_edge  = usb_s & ~usb_d_reg;
   assign lock_fall = lock_d_reg & ~lock_s;

   // ---------------------------------------------------------------------
   // State and counters
   // ---------------------------------------------------------------------
   state_t             state_reg,           state_next;
   logic [STAB_W-1:0]  stab_cnt_reg,        stab_cnt_next;
   logic [WIN_W-1:0]   win_cnt_reg,         win_cnt_next;
   logic [CNT_W-1:0]   edge_cnt_reg,        edge_cnt_next;
   logic [HOLD_W-1:0]  holdoff_cnt_reg,     holdoff_cnt_next;
   logic [CNT_W-1:0]   freq_count_reg,      freq_count_next;
   logic               freq_valid_reg,      freq_valid_next;
   logic [CNT_W-1:0]   lock_lost_count_reg, lock_lost_count_next;
   logic               usb_reset_reg,       usb_reset_next;
   logic               ready_reg,           ready_next;
   logic               fault_reg,           fault_next;

   // Edge count including an edge seen on the current cycle, so an edge on
   // the final window cycle lands in the closing window.
   logic [CNT_W-1:0] window_total;
   logic             in_range;
   logic             win_end;

   assign window_total = sat_inc(edge_cnt_reg, usb_edge);
   assign in_range     = (window_total >= F_MIN) && (window_total <= F_MAX);
   assign win_end      = (win_cnt_reg == WIN_LAST);

   always_comb begin
      state_next           = state_reg;
      stab_cnt_next        = '0;
      win_cnt_next         = '0;
      edge_cnt_next        = '0;
      holdoff_cnt_next     = '0;
      freq_count_next      = freq_count_reg;
      freq_valid_next      = 1'b0;
      lock_lost_count_next = sat_inc(lock_lost_count_reg, lock_fall);

      case (state_reg)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_next = STABILIZE;
            end
         end

         STABILIZE: begin
            if (!lock_s) begin
               state_next = WAIT_LOCK;
            end else if (stab_cnt_reg == STAB_LAST) begin
               // Window counters are already zero here, so MEASURE starts clean.
               state_next = MEASURE;
            end else begin
               stab_cnt_next = stab_cnt_reg + 1'b1;
            end
         end

         MEASURE, RUN: begin
            if (!lock_s) begin
               // Lock loss beats a coincident window end: result dropped.
               state_next = WAIT_LOCK;
            end else if (win_end) begin
               freq_count_next = window_total;
               freq_valid_next = 1'b1;
               state_next      = in_range ? RUN : FAULT;
               // win/edge counters fall back to 0 for a back-to-back window.
            end else begin
               win_cnt_next  = win_cnt_reg + 1'b1;
               edge_cnt_next = window_total;
            end
         end

         FAULT: begin
            // Lock loss is only counted here; the holdoff always completes.
            if (holdoff_cnt_reg == HOLD_LAST) begin
               state_next = WAIT_LOCK;
            end else begin
               holdoff_cnt_next = holdoff_cnt_reg + 1'b1;
            end
         end

         default: begin
            state_next = WAIT_LOCK;
         end
      endcase

      // Outputs are registered from the next state so they change on the
      // same edge as the state itself.
      usb_reset_next = (state_next != RUN);
      ready_next     = (state_next == RUN);
      fault_next     = (state_next == FAULT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg           <= WAIT_LOCK;
         stab_cnt_reg        <= '0;
         win_cnt_reg         <= '0;
         edge_cnt_reg        <= '0;
         holdoff_cnt_reg     <= '0;
         freq_count_reg      <= '0;
         freq_valid_reg      <= 1'b0;
         lock_lost_count_reg <= '0;
         usb_reset_reg       <= 1'b1;
         ready_reg           <= 1'b0;
         fault_reg           <= 1'b0;
      end else begin
         state_reg           <= state_next;
         stab_cnt_reg        <= stab_cnt_next;
         win_cnt_reg         <= win_cnt_next;
         edge_cnt_reg        <= edge_cnt_next;
         holdoff_cnt_reg     <= holdoff_cnt_next;
         freq_count_reg      <= freq_count_next;
         freq_valid_reg      <= freq_valid_next;
         lock_lost_count_reg <= lock_lost_count_next;
         usb_reset_reg       <= usb_reset_next;
         ready_reg           <= ready_next;
         fault_reg           <= fault_next;
      end
   end

   assign usb_reset       = usb_reset_reg;
   assign ready           = ready_reg;
   assign freq_count      = freq_count_reg;
   assign freq_valid      = freq_valid_reg;
   assign lock_lost_count = lock_lost_count_reg;
   assign fault           = fault_reg;

endmodule

// File: tb/tb_pll_usb_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_usb_supervisor
// Directed bench for pll_usb_supervisor. The USB clock sample is produced as
// one-cycle pulses spaced by an accumulator, so any 1000 consecutive clk
// cycles hold exactly usb_rate rising edges.
// ---------------------------------------------------------------------------
module tb_pll_usb_supervisor;
   import pll_usb_supervisor_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       usb_clk_sample;
   logic       usb_reset;
   logic       ready;
   logic [7:0] freq_count;
   logic       freq_valid;
   logic [7:0] lock_lost_count;
   logic       fault;

   int tests  = 0;
   int failed = 0;
   int usb_rate = 0;

   pll_usb_supervisor dut (
      .clk             (clk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .usb_clk_sample  (usb_clk_sample),
      .usb_reset       (usb_reset),
      .ready           (ready),
      .freq_count      (freq_count),
      .freq_valid      (freq_valid),
      .lock_lost_count (lock_lost_count),
      .fault           (fault)
   );

   initial forever #5 clk = ~clk;

   // USB clock generator: usb_rate pulses per 1000 clk cycles.
   initial begin
      int acc;
      acc = 0;
      usb_clk_sample = 1'b0;
      forever begin
         @(negedge clk);
         if (usb_rate == 0) begin
            usb_clk_sample = 1'b0;
         end else begin
            acc += usb_rate;
            if (acc >= 1000) begin
               acc -= 1000;
               usb_clk_sample = 1'b1;
            end else begin
               usb_clk_sample = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig_of(input int which);
      case (which)
         0:       return ready;
         1:       return freq_valid;
         2:       return fault;
         default: return usb_reset;
      endcase
   endfunction

   // Waits up to budget edges for the selected output to be high; n is the
   // edge count at which it was seen, or -1 on timeout.
   task automatic wait_for(input int which, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (sig_of(which)) begin
            n = i;
            break;
         end
      end
   endtask

   localparam int W_READY = 0;
   localparam int W_FV    = 1;
   localparam int W_FAULT = 2;

   int rate_tab  [3] = '{117, 123, 118};
   int ready_tab [3] = '{0, 0, 1};

   initial begin
      int n;
      int k;
      int m;

      // ---------------- reset ----------------
      rst = 1'b1;
      pll_locked = 1'b0;
      usb_rate = 120;
      repeat (4) @(posedge clk);
      #1;
      check("rst_usb_reset", usb_reset, 1);
      check("rst_ready", ready, 0);
      check("rst_freq_count", freq_count, 0);
      check("rst_freq_valid", freq_valid, 0);
      check("rst_lock_lost", lock_lost_count, 0);
      check("rst_fault", fault, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);

      // ---------------- 1: lock + 12 MHz -> RUN ----------------
      @(negedge clk);
      pll_locked = 1'b1;
      wait_for(W_READY, 3000, n);
      check("t1_ready_latency", n, 2027);
      check("t1_usb_reset", usb_reset, 0);
      check("t1_freq_count", freq_count, 120);
      check("t1_freq_valid", freq_valid, 1);
      check("t1_fault", fault, 0);
      @(posedge clk);
      #1;
      check("t1_freq_valid_pulse", freq_valid, 0);
      check("t1_ready_hold", ready, 1);
      $display("[TB] t1 lock-up done, freq_count=%0d", freq_count);

      // ---------------- 2: 3-cycle lock drop in RUN ----------------
      repeat (50) @(posedge clk);
      @(negedge clk);
      pll_locked = 1'b0;
      k = 0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         if (usb_reset && k == 0) k = i;
      end
      check("t2_reset_latency", k, 3);
      check("t2_ready", ready, 0);
      check("t2_lock_lost", lock_lost_count, 1);
      @(negedge clk);
      pll_locked = 1'b1;
      wait_for(W_READY, 3000, n);
      check("t2_relock_latency", n, 2027);
      check("t2_freq_count", freq_count, 120);
      $display("[TB] t2 lock drop recovered after %0d cycles", n);

      // ---------------- 3: 10 MHz in MEASURE -> FAULT ----------------
      @(negedge clk);
      pll_locked = 1'b0;
      usb_rate = 100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      pll_locked = 1'b1;
      wait_for(W_FAULT, 3000, n);
      check("t3_fault_latency", n, 2027);
      check("t3_freq_count", freq_count, 100);
      check("t3_freq_valid", freq_valid, 1);
      check("t3_ready", ready, 0);
      check("t3_usb_reset", usb_reset, 1);
      check("t3_lock_lost", lock_lost_count, 2);
      m = 1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (fault) m++;
         else break;
      end
      check("t3_fault_cycles", m, 256);
      check("t3_after_usb_reset", usb_reset, 1);
      check("t3_after_ready", ready, 0);
      $display("[TB] t3 fault held %0d cycles", m);

      // ---------------- 4: 12 -> 13 MHz in RUN, boundaries ----------------
      @(negedge clk);
      usb_rate = 120;
      wait_for(W_READY, 3000, n);
      check("t4_ready_seen", (n > 0), 1);
      repeat (900) @(posedge clk);
      @(negedge clk);
      usb_rate = 130;
      wait_for(W_FV, 1100, n);
      check("t4_mixed_seen", (n > 0), 1);
      check("t4_mixed_in_range", (freq_count >= 120 && freq_count <= 122), 1);
      check("t4_mixed_ready", ready, 1);
      wait_for(W_FV, 1100, n);
      check("t4_window_period", n, 1000);
      check("t4_freq_count_130", freq_count, 130);
      check("t4_fault", fault, 1);
      check("t4_ready_drop", ready, 0);
      check("t4_usb_reset", usb_reset, 1);
      $display("[TB] t4 13 MHz window freq_count=%0d", freq_count);

      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         usb_rate = rate_tab[t];
         wait_for(W_FV, 4000, n);
         check("t4_bnd_seen", (n > 0), 1);
         check("t4_bnd_count", freq_count, rate_tab[t]);
         check("t4_bnd_ready", ready, ready_tab[t]);
         check("t4_bnd_fault", fault, 1 - ready_tab[t]);
         $display("[TB] t4 boundary rate=%0d ready=%0d", rate_tab[t], ready);
      end

      @(negedge clk);
      usb_rate = 122;
      wait_for(W_FV, 1100, n);
      check("t4_122_mixed_ready", ready, 1);
      wait_for(W_FV, 1100, n);
      check("t4_122_count", freq_count, 122);
      check("t4_122_ready", ready, 1);
      $display("[TB] t4 boundary rate=122 ready=%0d", ready);

      // ---------------- 5: lock toggling, window-end lock loss ----------------
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         pll_locked = 1'b0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         pll_locked = 1'b1;
         repeat (3) @(posedge clk);
         if (i == 9) begin
            #1;
            check("t5_lock_lost_12", lock_lost_count, 12);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      check("t5_lock_lost_sat", lock_lost_count, 255);
      $display("[TB] t5 lock_lost_count=%0d", lock_lost_count);

      wait_for(W_READY, 3000, n);
      check("t5_ready_seen", (n > 0), 1);
      check("t5_fv_with_ready", freq_valid, 1);
      repeat (997) @(posedge clk);
      @(negedge clk);
      pll_locked = 1'b0;
      @(posedge clk);
      #1;
      check("t5_fv_w998", freq_valid, 0);
      @(posedge clk);
      #1;
      check("t5_fv_w999", freq_valid, 0);
      check("t5_ready_w999", ready, 1);
      @(posedge clk);
      #1;
      check("t5_fv_window_end", freq_valid, 0);
      check("t5_ready_window_end", ready, 0);
      check("t5_usb_reset_window_end", usb_reset, 1);
      @(posedge clk);
      #1;
      check("t5_fv_after", freq_valid, 0);
      check("t5_lock_lost_hold", lock_lost_count, 255);
      $display("[TB] t5 window-end lock loss, freq_valid=%0d", freq_valid);

      // ---------------- 6: rst during RUN ----------------
      @(negedge clk);
      pll_locked = 1'b1;
      wait_for(W_READY, 3000, n);
      check("t6_ready_seen", (n > 0), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_usb_reset", usb_reset, 1);
      check("t6_ready", ready, 0);
      check("t6_freq_count", freq_count, 0);
      check("t6_freq_valid", freq_valid, 0);
      check("t6_lock_lost", lock_lost_count, 0);
      check("t6_fault", fault, 0);
      check("t6_state", 32'(dut.state_reg), 32'(WAIT_LOCK));
      $display("[TB] t6 reset in RUN applied");
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
